// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the sram arbiter: owner encoding and the registered
// response record that tracks who gets the next sram read data.
package sram_arbiter_pkg;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    typedef struct packed {
        logic vld;
        logic owner;
        logic is_wr;
    } resp_t;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way IF/MEM picker: fixed MEM priority or round-robin, with a
// starvation counter that force-grants IF after STARVE_MAX lost ties.
module rr_arb2
    import sram_arbiter_pkg::*;
#(
    parameter int MEM_PRIO   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic mem_req,
    output logic if_gnt,
    output logic mem_gnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       rr_last;
    logic [3:0] starve_cnt;
    logic       if_pick;
    logic       mem_pick;

    always_comb begin
        if_pick  = 1'b0;
        mem_pick = 1'b0;
        if (if_req && mem_req) begin
            if (starve_cnt == STARVE_LIM) begin
                if_pick = 1'b1;
            end else if (MEM_PRIO != 0) begin
                mem_pick = 1'b1;
            end else if (rr_last == OWNER_IF) begin
                mem_pick = 1'b1;
            end else begin
                if_pick = 1'b1;
            end
        end else begin
            if_pick  = if_req;
            mem_pick = mem_req;
        end
    end

    // Grants are forced low while reset is asserted so nothing reaches the sram.
    assign if_gnt  = if_pick & rst_n;
    assign mem_gnt = mem_pick & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last    <= OWNER_IF;
            starve_cnt <= '0;
        end else begin
            if (if_gnt) begin
                rr_last <= OWNER_IF;
            end else if (mem_gnt) begin
                rr_last <= OWNER_MEM;
            end

            if (!if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (mem_gnt && starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port sram between instruction fetch (read-only) and the
// load/store unit; one access per cycle, response routed back one cycle later.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_PRIO   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req,
    input  logic [DATA_W/8-1:0] mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_gnt,
    output logic                mem_rvalid,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    logic  if_pick;
    logic  mem_pick;
    resp_t resp_d;
    resp_t resp_q;

    rr_arb2 #(
        .MEM_PRIO  (MEM_PRIO),
        .STARVE_MAX(STARVE_MAX)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (if_req),
        .mem_req(mem_req),
        .if_gnt (if_pick),
        .mem_gnt(mem_pick)
    );

    assign if_gnt  = if_pick;
    assign mem_gnt = mem_pick;

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (mem_pick) begin
            sram_en    = 1'b1;
            sram_we    = mem_we;
            sram_addr  = mem_addr;
            sram_wdata = mem_wdata;
        end else if (if_pick) begin
            sram_en   = 1'b1;
            sram_addr = if_addr;
        end
    end

    always_comb begin
        resp_d.vld   = if_pick | mem_pick;
        resp_d.owner = mem_pick ? OWNER_MEM : OWNER_IF;
        resp_d.is_wr = mem_pick & (|mem_we);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= '{vld: 1'b0, owner: OWNER_IF, is_wr: 1'b0};
        end else begin
            resp_q <= resp_d;
        end
    end

    // Only the owner sees the response; write acks carry zero data.
    always_comb begin
        if_rvalid  = resp_q.vld & (resp_q.owner == OWNER_IF);
        mem_rvalid = resp_q.vld & (resp_q.owner == OWNER_MEM);
        if_rdata   = if_rvalid ? sram_rdata : '0;
        mem_rdata  = (mem_rvalid && !resp_q.is_wr) ? sram_rdata : '0;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a MEM-priority instance and a round-robin
// instance share stimulus, each backed by a small behavioural sram.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        mem_req = 1'b0;
    logic [7:0]  mem_we = '0;
    logic [63:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;

    logic        p_if_gnt, p_if_rvalid, p_mem_gnt, p_mem_rvalid, p_sram_en;
    logic [63:0] p_if_rdata, p_mem_rdata, p_sram_addr, p_sram_wdata;
    logic [7:0]  p_sram_we;
    logic [63:0] p_sram_rdata = '0;
    logic        r_if_gnt, r_if_rvalid, r_mem_gnt, r_mem_rvalid, r_sram_en;
    logic [63:0] r_if_rdata, r_mem_rdata, r_sram_addr, r_sram_wdata;
    logic [7:0]  r_sram_we;
    logic [63:0] r_sram_rdata = '0;

    logic [63:0] mem_p [16] = '{1: 64'hDEADBEEF, default: 64'h0};
    logic [63:0] mem_r [16] = '{1: 64'hDEADBEEF, default: 64'h0};

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_PRIO(1), .STARVE_MAX(4)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(p_if_gnt),
        .if_rvalid(p_if_rvalid), .if_rdata(p_if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(p_mem_gnt), .mem_rvalid(p_mem_rvalid), .mem_rdata(p_mem_rdata),
        .sram_en(p_sram_en), .sram_we(p_sram_we), .sram_addr(p_sram_addr),
        .sram_wdata(p_sram_wdata), .sram_rdata(p_sram_rdata)
    );

    sram_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_PRIO(0), .STARVE_MAX(4)) dut_r (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(r_if_gnt),
        .if_rvalid(r_if_rvalid), .if_rdata(r_if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(r_mem_gnt), .mem_rvalid(r_mem_rvalid), .mem_rdata(r_mem_rdata),
        .sram_en(r_sram_en), .sram_we(r_sram_we), .sram_addr(r_sram_addr),
        .sram_wdata(r_sram_wdata), .sram_rdata(r_sram_rdata)
    );

    // Behavioural sram: word index addr[6:3], byte-masked write, 1-cycle read.
    always @(posedge clk) begin
        if (p_sram_en) begin
            for (int b = 0; b < 8; b++)
                if (p_sram_we[b]) mem_p[p_sram_addr[6:3]][b*8 +: 8] <= p_sram_wdata[b*8 +: 8];
            p_sram_rdata <= mem_p[p_sram_addr[6:3]];
        end
        if (r_sram_en) begin
            for (int b = 0; b < 8; b++)
                if (r_sram_we[b]) mem_r[r_sram_addr[6:3]][b*8 +: 8] <= r_sram_wdata[b*8 +: 8];
            r_sram_rdata <= mem_r[r_sram_addr[6:3]];
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        if_req = 1'b0;
        mem_req = 1'b0;
        mem_we = '0;
        mem_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1;
        mem_req = 1'b1;
        if_addr = 64'h8000_0008;
        mem_addr = 64'h8000_0010;
        repeat (2) @(negedge clk);
        #1;
        total++; if (p_if_gnt !== 1'b0) begin bad++; $display("FAIL rst_if_gnt got=%0h want=0", p_if_gnt); end
        total++; if (p_mem_gnt !== 1'b0) begin bad++; $display("FAIL rst_mem_gnt got=%0h want=0", p_mem_gnt); end
        total++; if (p_sram_en !== 1'b0) begin bad++; $display("FAIL rst_sram_en got=%0h want=0", p_sram_en); end
        total++; if (p_sram_addr !== 64'h0) begin bad++; $display("FAIL rst_sram_addr got=%0h want=0", p_sram_addr); end
        total++; if (p_if_rvalid !== 1'b0) begin bad++; $display("FAIL rst_if_rvalid got=%0h want=0", p_if_rvalid); end
        total++; if (p_mem_rvalid !== 1'b0) begin bad++; $display("FAIL rst_mem_rvalid got=%0h want=0", p_mem_rvalid); end
        total++; if (r_mem_gnt !== 1'b0) begin bad++; $display("FAIL rst_rr_mem_gnt got=%0h want=0", r_mem_gnt); end
        rst_n = 1'b1;
        #1;
        total++; if (p_mem_gnt !== 1'b1) begin bad++; $display("FAIL rel_mem_gnt got=%0h want=1", p_mem_gnt); end
        total++; if (p_if_gnt !== 1'b0) begin bad++; $display("FAIL rel_if_gnt got=%0h want=0", p_if_gnt); end
        total++; if (r_mem_gnt !== 1'b1) begin bad++; $display("FAIL rel_rr_mem_gnt got=%0h want=1", r_mem_gnt); end
        step();
        idle();
        total++; if (p_mem_rvalid !== 1'b1) begin bad++; $display("FAIL rel_mem_rvalid got=%0h want=1", p_mem_rvalid); end
        total++; if (p_if_rvalid !== 1'b0) begin bad++; $display("FAIL rel_if_rvalid got=%0h want=0", p_if_rvalid); end
        step();
        total++; if (p_mem_rvalid !== 1'b0) begin bad++; $display("FAIL rel_rvalid_pulse got=%0h want=0", p_mem_rvalid); end
    endtask

    task automatic test_if_read();
        if_req = 1'b1;
        if_addr = 64'h8000_0008;
        #1;
        total++; if (p_if_gnt !== 1'b1) begin bad++; $display("FAIL ifrd_gnt got=%0h want=1", p_if_gnt); end
        total++; if (p_mem_gnt !== 1'b0) begin bad++; $display("FAIL ifrd_mem_gnt got=%0h want=0", p_mem_gnt); end
        total++; if (p_sram_en !== 1'b1) begin bad++; $display("FAIL ifrd_sram_en got=%0h want=1", p_sram_en); end
        total++; if (p_sram_addr !== 64'h8000_0008) begin bad++; $display("FAIL ifrd_sram_addr got=%0h want=80000008", p_sram_addr); end
        total++; if (p_sram_we !== 8'h00) begin bad++; $display("FAIL ifrd_sram_we got=%0h want=0", p_sram_we); end
        step();
        idle();
        total++; if (p_if_rvalid !== 1'b1) begin bad++; $display("FAIL ifrd_rvalid got=%0h want=1", p_if_rvalid); end
        total++; if (p_if_rdata !== 64'hDEADBEEF) begin bad++; $display("FAIL ifrd_rdata got=%0h want=deadbeef", p_if_rdata); end
        total++; if (p_mem_rvalid !== 1'b0) begin bad++; $display("FAIL ifrd_mem_rvalid got=%0h want=0", p_mem_rvalid); end
        #1;
        total++; if (p_sram_en !== 1'b0) begin bad++; $display("FAIL ifrd_idle_en got=%0h want=0", p_sram_en); end
        step();
    endtask

    task automatic test_mem_write_read();
        mem_req = 1'b1;
        mem_we = 8'hFF;
        mem_addr = 64'h8000_0010;
        mem_wdata = 64'h1234;
        #1;
        total++; if (p_mem_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%0h want=1", p_mem_gnt); end
        total++; if (p_sram_we !== 8'hFF) begin bad++; $display("FAIL wr_sram_we got=%0h want=ff", p_sram_we); end
        total++; if (p_sram_wdata !== 64'h1234) begin bad++; $display("FAIL wr_sram_wdata got=%0h want=1234", p_sram_wdata); end
        step();
        total++; if (p_mem_rvalid !== 1'b1) begin bad++; $display("FAIL wr_ack_vld got=%0h want=1", p_mem_rvalid); end
        total++; if (p_mem_rdata !== 64'h0) begin bad++; $display("FAIL wr_ack_data got=%0h want=0", p_mem_rdata); end
        mem_we = 8'h00;
        mem_wdata = '0;
        #1;
        total++; if (p_sram_we !== 8'h00) begin bad++; $display("FAIL rd_sram_we got=%0h want=0", p_sram_we); end
        step();
        total++; if (p_mem_rvalid !== 1'b1) begin bad++; $display("FAIL rd1_vld got=%0h want=1", p_mem_rvalid); end
        total++; if (p_mem_rdata !== 64'h1234) begin bad++; $display("FAIL rd1_data got=%0h want=1234", p_mem_rdata); end
        #1;
        total++; if (p_mem_gnt !== 1'b1) begin bad++; $display("FAIL rd2_gnt got=%0h want=1", p_mem_gnt); end
        step();
        total++; if (p_mem_rvalid !== 1'b1) begin bad++; $display("FAIL rd2_vld got=%0h want=1", p_mem_rvalid); end
        total++; if (p_mem_rdata !== 64'h1234) begin bad++; $display("FAIL rd2_data got=%0h want=1234", p_mem_rdata); end
        // byte 1 only: 0x1234 becomes 0xAB34
        mem_we = 8'h02;
        mem_wdata = 64'hFFFF_FFFF_FFFF_AB00;
        step();
        mem_we = 8'h00;
        mem_wdata = '0;
        step();
        idle();
        total++; if (p_mem_rdata !== 64'hAB34) begin bad++; $display("FAIL mask_rd_data got=%0h want=ab34", p_mem_rdata); end
        step();
        total++; if (p_mem_rvalid !== 1'b0) begin bad++; $display("FAIL rd_end_vld got=%0h want=0", p_mem_rvalid); end
    endtask

    task automatic test_mem_prio_starve();
        logic [9:0] pat;
        pat = 10'b0111101111;
        if_req = 1'b1;
        mem_req = 1'b1;
        if_addr = 64'h8000_0008;
        mem_addr = 64'h8000_0010;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                total++; if (p_mem_rvalid !== pat[i-1]) begin bad++; $display("FAIL starve_mem_rvalid[%0d] got=%0h want=%0h", i, p_mem_rvalid, pat[i-1]); end
                total++; if (p_if_rvalid !== !pat[i-1]) begin bad++; $display("FAIL starve_if_rvalid[%0d] got=%0h want=%0h", i, p_if_rvalid, !pat[i-1]); end
            end
            #1;
            total++; if (p_mem_gnt !== pat[i]) begin bad++; $display("FAIL starve_mem_gnt[%0d] got=%0h want=%0h", i, p_mem_gnt, pat[i]); end
            total++; if (p_if_gnt !== !pat[i]) begin bad++; $display("FAIL starve_if_gnt[%0d] got=%0h want=%0h", i, p_if_gnt, !pat[i]); end
            step();
        end
        idle();
        total++; if (p_if_rvalid !== 1'b1) begin bad++; $display("FAIL starve_last_vld got=%0h want=1", p_if_rvalid); end
        total++; if (p_if_rdata !== 64'hDEADBEEF) begin bad++; $display("FAIL starve_last_data got=%0h want=deadbeef", p_if_rdata); end
        step();
    endtask

    task automatic test_reset_mid_op();
        if_req = 1'b1;
        mem_req = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        total++; if (p_mem_rvalid !== 1'b0) begin bad++; $display("FAIL mid_mem_rvalid got=%0h want=0", p_mem_rvalid); end
        total++; if (p_mem_gnt !== 1'b0) begin bad++; $display("FAIL mid_mem_gnt got=%0h want=0", p_mem_gnt); end
        total++; if (dut_p.u_arb.starve_cnt !== 4'd0) begin bad++; $display("FAIL mid_starve got=%0d want=0", dut_p.u_arb.starve_cnt); end
        idle();
        step();
        rst_n = 1'b1;
        #1;
        total++; if (p_mem_rvalid !== 1'b0) begin bad++; $display("FAIL mid_post_rvalid got=%0h want=0", p_mem_rvalid); end
        if_req = 1'b1;
        #1;
        total++; if (p_if_gnt !== 1'b1) begin bad++; $display("FAIL mid_if_gnt got=%0h want=1", p_if_gnt); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle();
        #1;
        total++; if (p_if_rvalid !== 1'b0) begin bad++; $display("FAIL mid_if_rvalid got=%0h want=0", p_if_rvalid); end
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();
        total++; if (p_if_rvalid !== 1'b0) begin bad++; $display("FAIL mid_after_if got=%0h want=0", p_if_rvalid); end
        total++; if (p_mem_rvalid !== 1'b0) begin bad++; $display("FAIL mid_after_mem got=%0h want=0", p_mem_rvalid); end
        total++; if (dut_p.u_arb.starve_cnt !== 4'd0) begin bad++; $display("FAIL mid_after_starve got=%0d want=0", dut_p.u_arb.starve_cnt); end
    endtask

    task automatic test_round_robin();
        logic [7:0] pat;
        pat = 8'b01010101;
        if_req = 1'b1;
        mem_req = 1'b1;
        if_addr = 64'h8000_0008;
        mem_addr = 64'h8000_0010;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                total++; if (r_mem_rvalid !== pat[i-1]) begin bad++; $display("FAIL rr_mem_rvalid[%0d] got=%0h want=%0h", i, r_mem_rvalid, pat[i-1]); end
                total++; if (r_if_rvalid !== !pat[i-1]) begin bad++; $display("FAIL rr_if_rvalid[%0d] got=%0h want=%0h", i, r_if_rvalid, !pat[i-1]); end
            end
            #1;
            total++; if (r_mem_gnt !== pat[i]) begin bad++; $display("FAIL rr_mem_gnt[%0d] got=%0h want=%0h", i, r_mem_gnt, pat[i]); end
            total++; if (r_if_gnt !== !pat[i]) begin bad++; $display("FAIL rr_if_gnt[%0d] got=%0h want=%0h", i, r_if_gnt, !pat[i]); end
            step();
        end
        idle();
        total++; if (r_if_rdata !== 64'hDEADBEEF) begin bad++; $display("FAIL rr_if_rdata got=%0h want=deadbeef", r_if_rdata); end
        total++; if (r_mem_rdata !== 64'h0) begin bad++; $display("FAIL rr_mem_rdata got=%0h want=0", r_mem_rdata); end
        step();
    endtask

    task automatic test_drop_req();
        if_req = 1'b1;
        mem_req = 1'b1;
        #1;
        total++; if (p_if_gnt !== 1'b0) begin bad++; $display("FAIL drop_if_lost got=%0h want=0", p_if_gnt); end
        step();
        idle();
        #1;
        total++; if (p_sram_en !== 1'b0) begin bad++; $display("FAIL drop_sram_en got=%0h want=0", p_sram_en); end
        step();
        total++; if (p_if_rvalid !== 1'b0) begin bad++; $display("FAIL drop_if_rvalid got=%0h want=0", p_if_rvalid); end
        total++; if (p_mem_rvalid !== 1'b0) begin bad++; $display("FAIL drop_mem_rvalid got=%0h want=0", p_mem_rvalid); end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_write_read();
        test_mem_prio_starve();
        test_reset_mid_op();
        test_round_robin();
        test_drop_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
